// File: rtl/am_demod.sv
// am_demod: digital AM envelope demodulator.
// Full-wave rectifies signed carrier samples (registered), integrates-and-dumps
// over DECIM = 2**LOG2_DEC valid samples, and presents one envelope sample per
// window on a valid/ready output. If the output is still full when a new result
// arrives, that result is dropped and the sticky overflow flag is set.
// Optional feature macro: DC_BLOCK_EN. When it is defined, a carrier-level
// tracker runs after the dump stage and adds one cycle of latency.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   enable               1 = demodulate, 0 = idle (partial window discarded)
//   in_valid, in_data    signed carrier sample stream (no backpressure)
//   out_valid, out_ready envelope handshake
//   out_data             envelope (zero-extended, or signed when DC-blocked)
//   overflow, clr_ovf    sticky drop flag and its synchronous clear
module am_demod #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned LOG2_DEC = 4,
    parameter int unsigned DC_SHIFT = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              overflow,
    input  logic              clr_ovf
);
    localparam int unsigned MAG_W = DATA_W - 1;
    localparam int unsigned ACC_W = MAG_W + LOG2_DEC;
    localparam int unsigned CNT_W = LOG2_DEC;

    // Elaboration-time range check on the configuration.
    if (LOG2_DEC < 1 || LOG2_DEC > 8 || DC_SHIFT > 2 * DATA_W) begin : g_param_check
        $error("am_demod: LOG2_DEC or DC_SHIFT out of range");
    end

    typedef enum logic [1:0] {IDLE, ACC, DUMP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [MAG_W-1:0]  rect;
    logic              rect_valid;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [MAG_W-1:0]  env;
    logic [DATA_W-1:0] neg_c;
    logic [MAG_W-1:0]  mag_c;
    logic [ACC_W-1:0]  sum_c;
    logic              integ_c;
    logic              last_c;
    logic              load_c;
    logic [DATA_W-1:0] res_c;

    // Magnitude of the input; the most negative code saturates to full scale.
    always_comb begin
        neg_c = ~in_data + DATA_W'(1);
        if (in_data[DATA_W-1] && (in_data[MAG_W-1:0] == '0)) begin
            mag_c = '1;
        end else if (in_data[DATA_W-1]) begin
            mag_c = neg_c[MAG_W-1:0];
        end else begin
            mag_c = in_data[MAG_W-1:0];
        end
    end

    // Rectify stage; dropping enable flushes the pending sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rect       <= '0;
            rect_valid <= 1'b0;
        end else begin
            rect_valid <= in_valid & enable;
            if (in_valid & enable) begin
                rect <= mag_c;
            end
        end
    end

    assign sum_c = acc + ACC_W'(rect);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; DUMP keeps integrating so consecutive windows are gapless.
    always_comb begin
        state_nxt = state;
        integ_c   = 1'b0;
        last_c    = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = ACC;
                ACC, DUMP: begin
                    state_nxt = ACC;
                    integ_c   = rect_valid;
                    last_c    = rect_valid && (&cnt);
                    if (last_c) begin
                        state_nxt = DUMP;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Integrate-and-dump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            env <= '0;
        end else if (!enable) begin
            acc <= '0;
            cnt <= '0;
        end else if (last_c) begin
            acc <= '0;
            cnt <= '0;
            env <= sum_c[ACC_W-1:LOG2_DEC];
        end else if (integ_c) begin
            acc <= sum_c;
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef DC_BLOCK_EN
    localparam int unsigned DC_W = DATA_W + DC_SHIFT + 1;

    logic signed [DC_W-1:0] dc;
    logic signed [DC_W-1:0] dc_diff_c;
    logic signed [DC_W-1:0] dc_step_c;
    logic signed [DC_W-1:0] dc_shr_c;
    logic        [DATA_W:0] y_full_c;
    logic [DATA_W-1:0]      y_sat_c;
    logic [DATA_W-1:0]      y_q;
    logic                   y_valid;

    // Subtract the integer part of the tracked carrier level, then move the
    // tracker (DC_SHIFT fraction bits) toward the envelope.
    always_comb begin
        dc_shr_c  = dc >>> DC_SHIFT;
        y_full_c  = {2'b00, env} - dc_shr_c[DATA_W:0];
        dc_diff_c = {2'b00, env, {DC_SHIFT{1'b0}}} - dc;
        dc_step_c = dc_diff_c >>> DC_SHIFT;
        if (y_full_c[DATA_W] != y_full_c[DATA_W-1]) begin
            y_sat_c = y_full_c[DATA_W] ? {1'b1, {MAG_W{1'b0}}} : {1'b0, {MAG_W{1'b1}}};
        end else begin
            y_sat_c = y_full_c[DATA_W-1:0];
        end
    end

    // DC-block stage; a window already in DUMP completes even if enable drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc      <= '0;
            y_q     <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= (state == DUMP);
            if (state == DUMP) begin
                y_q <= y_sat_c;
                dc  <= dc + dc_step_c;
            end
        end
    end

    assign load_c = y_valid;
    assign res_c  = y_q;
`else
    assign load_c = (state == DUMP);
    assign res_c  = {1'b0, env};
`endif

    // Output register with drop-on-full and sticky overflow (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (load_c && (!out_valid || out_ready)) begin
                out_data  <= res_c;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (load_c && out_valid && !out_ready) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_am_demod.sv
// Bench for am_demod (DATA_W=12, DECIM=4): window-sum reference model feeding a
// scoreboard queue, checked by a monitor on each accepted output.
module tb_am_demod;
    localparam int unsigned DATA_W   = 12;
    localparam int unsigned LOG2_DEC = 2;
    localparam int unsigned DC_SHIFT = 1;
`ifdef DC_BLOCK_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              overflow;
    logic              clr_ovf = 1'b0;

    int checks = 0;
    int failures = 0;
    int n_out = 0;
    int n0;
    int dc_f = 0;
    bit hold = 1'b0;
    bit prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [DATA_W-1:0] mon_exp;
    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] held[$];
    int win[$];

    always #5 clk = ~clk;

    am_demod #(.DATA_W(DATA_W), .LOG2_DEC(LOG2_DEC), .DC_SHIFT(DC_SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int mag(input logic [DATA_W-1:0] d);
        int s;
        s = $signed(d);
        if (s < 0) s = -s;
        if (s > 2047) s = 2047;
        return s;
    endfunction

    // One envelope per completed window; optional carrier-level removal.
    task automatic emit(input int env);
        int y;
        y = env;
`ifdef DC_BLOCK_EN
        y = env - (dc_f >>> DC_SHIFT);
        if (y > 2047) y = 2047;
        if (y < -2048) y = -2048;
        dc_f = dc_f + (((env <<< DC_SHIFT) - dc_f) >>> DC_SHIFT);
`endif
        if (hold) held.push_back(DATA_W'(y));
        else sb.push_back(DATA_W'(y));
    endtask

    // Apply one cycle of input and update the window model: a window of four
    // valid samples completes on the next enabled cycle; enable low discards it.
    task automatic step(input bit en, input bit v, input int d);
        int s;
        enable   = en;
        in_valid = v;
        in_data  = DATA_W'(d);
        if (!en) begin
            win.delete();
        end else begin
            if (win.size() == 4) begin
                s = 0;
                foreach (win[i]) s += win[i];
                emit(s / 4);
                win.delete();
            end
            if (v) win.push_back(mag(DATA_W'(d)));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
    endtask

    // Monitor: compare each accepted output, and check stability under stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), int'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=%0d expected=none", out_data);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("envelope", int'(out_data), int'(mon_exp));
                end
                n_out++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;

        // Constant carrier with latency check.
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1000);
            if (i == 3 + LAT - 1) chk("lat_early", int'(out_valid), 0);
            if (i == 3 + LAT) chk("lat", int'(out_valid), 1);
        end
        flush(6);
        chk("t1_count", n_out - n0, 2);

        // Alternating sign, saturation, truncation.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, (i % 2) ? -1000 : 1000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, -2048);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 1);
        flush(6);
        chk("t3_drained", sb.size(), 0);

        // Backpressure: later results dropped, first one held.
        hold = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 700);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 300);
        flush(6);
        chk("t4_results", held.size(), 3);
        chk("t4_hold_valid", int'(out_valid), 1);
        chk("t4_hold_data", int'(out_data), int'(held[0]));
        chk("t4_ovf", int'(overflow), 1);
        hold = 1'b0;
        sb.push_back(held[0]);
        held.delete();
        n0 = n_out;
        out_ready = 1'b1;
        step(1'b1, 1'b0, 0);
        chk("t4_xfer", n_out - n0, 1);
        chk("t4_empty", int'(out_valid), 0);
        chk("t4_ovf_sticky", int'(overflow), 1);
        clr_ovf = 1'b1;
        step(1'b1, 1'b0, 0);
        clr_ovf = 1'b0;
        chk("t4_clr", int'(overflow), 0);

        // Enable drop discards the partial window.
        n0 = n_out;
        step(1'b1, 1'b1, 900);
        step(1'b1, 1'b1, 900);
        step(1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 500);
        flush(6);
        chk("t5_count", n_out - n0, 1);

        // Randomised stream; ready never low two cycles running, so no drops.
        step(1'b0, 1'b0, 0);
        for (int i = 0; i < 400; i++) begin
            int d;
            d = $urandom_range(0, 4095);
            if ($urandom_range(0, 19) == 0) d = -2048;
            if (!out_ready) out_ready = 1'b1;
            else out_ready = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 19) != 0, $urandom_range(0, 9) < 7, d);
        end
        out_ready = 1'b1;
        flush(8);
        chk("rnd_no_ovf", int'(overflow), 0);
        chk("rnd_drained", sb.size(), 0);

        // Asynchronous reset with an output pending.
        step(1'b0, 1'b0, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1000);
        flush(LAT + 1);
        chk("t7_pending", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", int'(out_valid), 0);
        chk("t7_rst_data", int'(out_data), 0);
        sb.delete();
        win.delete();
        dc_f = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1000);
        flush(8);
        chk("t7_count", n_out - n0, 2);
        chk("t7_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
